// File: rtl/ycbcr_pkg.sv
// Shared YCbCr/RGB colour-space constants, pixel type and the fixed-point clamp helper.
// Also meant for the RGB-to-YCbCr upstream stage.
package ycbcr_pkg;

  localparam int FRAC_BITS  = 8;
  localparam int ROUND_HALF = 128;
  localparam int OFFSET_128 = 128;

  // Full-range BT.601 coefficients scaled by 2^FRAC_BITS; sized to match the product width.
  localparam logic signed [17:0] KR  = 18'sd359;
  localparam logic signed [17:0] KGB = 18'sd88;
  localparam logic signed [17:0] KGR = 18'sd183;
  localparam logic signed [17:0] KB  = 18'sd454;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  // Returns {clamped, value}: the sum is dropped to integer and limited to 0..255.
  function automatic logic [8:0] clamp_u8(input logic signed [18:0] sum);
    logic signed [18:0] sh;
    sh = sum >>> FRAC_BITS;
    if (sh < 0) return 9'h100;
    if (sh > 19'sd255) return 9'h1ff;
    return {1'b0, sh[7:0]};
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Async-reset shift register that delays the {vsync, href, clken} bundle by DEPTH cycles.
module sync_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '{default: '0};
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/ycbcr2rgb888_stage.sv
// Full-range YCbCr444 to RGB888 conversion, 3-cycle pipeline with matched sync delay,
// plus a per-frame count of pixels where any channel saturated.
module ycbcr2rgb888_stage
  import ycbcr_pkg::*;
#(
  parameter int CLIP_W = 16,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [7:0]        per_img_Y,
  input  logic [7:0]        per_img_Cb,
  input  logic [7:0]        per_img_Cr,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [7:0]        post_img_red,
  output logic [7:0]        post_img_green,
  output logic [7:0]        post_img_blue,
  output logic [CLIP_W-1:0] clip_cnt,
  output logic              clip_valid
);

  logic signed [18:0] y2_c;
  logic signed [8:0]  dcb_c;
  logic signed [8:0]  dcr_c;

  logic signed [18:0] y2_q;
  logic signed [17:0] pr_q, pgb_q, pgr_q, pb_q;
  logic signed [18:0] sr_q, sg_q, sb_q;

  logic [8:0] clamp_r, clamp_g, clamp_b;
  rgb888_t    rgb_q;
  logic       hit_q;

  logic [2:0]        sync_out;
  logic              vsync_q;
  logic              qual_hit;
  logic              vsync_rise;
  logic [CLIP_W-1:0] acc;
  logic [CLIP_W-1:0] acc_next;

  always_comb begin
    y2_c  = $signed(19'(per_img_Y) << FRAC_BITS) + 19'(ROUND_HALF);
    dcb_c = $signed({1'b0, per_img_Cb}) - 9'(OFFSET_128);
    dcr_c = $signed({1'b0, per_img_Cr}) - 9'(OFFSET_128);
  end

  // The pipeline free-runs every clock; clken only qualifies the clip count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y2_q  <= '0;
      pr_q  <= '0;
      pgb_q <= '0;
      pgr_q <= '0;
      pb_q  <= '0;
      sr_q  <= '0;
      sg_q  <= '0;
      sb_q  <= '0;
      rgb_q <= '0;
      hit_q <= 1'b0;
    end else begin
      y2_q  <= y2_c;
      pr_q  <= KR  * 18'(dcr_c);
      pgb_q <= KGB * 18'(dcb_c);
      pgr_q <= KGR * 18'(dcr_c);
      pb_q  <= KB  * 18'(dcb_c);
      sr_q  <= y2_q + 19'(pr_q);
      sg_q  <= y2_q - 19'(pgb_q) - 19'(pgr_q);
      sb_q  <= y2_q + 19'(pb_q);
      rgb_q <= '{red: clamp_r[7:0], green: clamp_g[7:0], blue: clamp_b[7:0]};
      hit_q <= clamp_r[8] | clamp_g[8] | clamp_b[8];
    end
  end

  always_comb begin
    clamp_r = clamp_u8(sr_q);
    clamp_g = clamp_u8(sg_q);
    clamp_b = clamp_u8(sb_q);
  end

  sync_delay_line #(
    .DEPTH(LAT),
    .WIDTH(3)
  ) u_sync_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({per_frame_vsync, per_frame_href, per_frame_clken}),
    .dout (sync_out)
  );

  assign {post_frame_vsync, post_frame_href, post_frame_clken} = sync_out;

  assign post_img_red   = post_frame_href ? rgb_q.red   : 8'd0;
  assign post_img_green = post_frame_href ? rgb_q.green : 8'd0;
  assign post_img_blue  = post_frame_href ? rgb_q.blue  : 8'd0;

  assign qual_hit   = hit_q & post_frame_href & post_frame_clken;
  assign vsync_rise = post_frame_vsync & ~vsync_q;
  assign acc_next   = (&acc) ? acc : acc + {{(CLIP_W-1){1'b0}}, qual_hit};

  // A hit landing on the vsync edge still belongs to the frame being closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      acc        <= '0;
      clip_cnt   <= '0;
      clip_valid <= 1'b0;
    end else begin
      vsync_q    <= post_frame_vsync;
      clip_valid <= vsync_rise;
      if (vsync_rise) begin
        clip_cnt <= acc_next;
        acc      <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule
